dff_pipe_hs: RTL

Parametrised multi-stage register pipeline with a valid/ready handshake on both ends. It generalises the single-register DFF primitive in three ways: configurable depth, per-stage valid tracking with bubble collapse, and synchronous flush. It sits between register-file datapath blocks that need retiming without losing backpressure.

---
 rtl/dff_pkg.sv | 12 +
 rtl/dff_hs_stage.sv | 59 +++++
 rtl/dff_pipe_hs.sv | 107 ++++++++++
 3 files changed

// File: rtl/dff_pkg.sv
// dff_pkg: shared constants and helpers for the dff_pipe_hs pipeline.
//   DFF_DEPTH_MAX : largest stage count the pipeline may be built with.
//   cnt_w(depth)  : width needed to hold an occupancy count of 0..depth.
package dff_pkg;

  localparam int unsigned DFF_DEPTH_MAX = 64;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_hs_stage.sv
// dff_hs_stage: one pipeline stage (valid bit + data register) together with
// its term of the ready chain.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   flush_i         synchronous clear of the valid bit (data holds)
//   prev_valid_i    valid of the upstream stage (or the pipeline input)
//   prev_data_i     data of the upstream stage (or the pipeline input)
//   next_ready_i    ready of the downstream stage (or the pipeline output)
//   ready_o         this stage can take a beat: empty, or its beat moves on
//   valid_o         registered valid bit
//   data_o          registered payload
module dff_hs_stage
  import dff_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] DATA_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  prev_valid_i,
  input  logic [DATA_WIDTH-1:0] prev_data_i,
  input  logic                  next_ready_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  assign ready_o = !valid_q || next_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (ready_o) begin
      valid_d = prev_valid_i;
      // Data only moves with a real beat so bubbles do not toggle the register.
      if (prev_valid_i) data_d = prev_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= DATA_VALUE;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/dff_pipe_hs.sv
// dff_pipe_hs: DEPTH-stage register pipeline with valid/ready handshakes on
// both ends, bubble collapse and synchronous flush.
// Ports:
//   clk, rst             clock and asynchronous active-high reset
//   flush                clear every stage's valid bit on the next edge
//   in_valid/in_ready    upstream handshake, in_data payload
//   out_valid/out_ready  downstream handshake, out_data payload (last stage)
//   occupancy            registered count of valid stages (0..DEPTH)
module dff_pipe_hs
  import dff_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           DEPTH      = 3,
  parameter logic [DATA_WIDTH-1:0] DATA_VALUE = '0,
  parameter int unsigned           CNT_W      = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      occupancy
);

  if (DEPTH < 1 || DEPTH > DFF_DEPTH_MAX) begin : g_bad_depth
    $error("dff_pipe_hs: DEPTH %0d outside 1..%0d", DEPTH, DFF_DEPTH_MAX);
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("dff_pipe_hs: DATA_WIDTH must be at least 1");
  end

  logic [DEPTH-1:0]      v;
  logic [DATA_WIDTH-1:0] d [DEPTH];

  // Each stage keeps its own ready nets so the chain is a set of distinct
  // signals rather than one vector feeding back into itself.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic                  rdy_up;
    logic                  rdy_dn;
    logic                  prv_vld;
    logic [DATA_WIDTH-1:0] prv_dat;

    if (i == DEPTH - 1) begin : g_tail
      assign rdy_dn = out_ready;
    end else begin : g_body
      assign rdy_dn = g_stage[i+1].rdy_up;
    end

    if (i == 0) begin : g_head
      assign prv_vld = in_valid;
      assign prv_dat = in_data;
    end else begin : g_link
      assign prv_vld = v[i-1];
      assign prv_dat = d[i-1];
    end

    dff_hs_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .DATA_VALUE (DATA_VALUE)
    ) u_stage (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (flush),
      .prev_valid_i (prv_vld),
      .prev_data_i  (prv_dat),
      .next_ready_i (rdy_dn),
      .ready_o      (rdy_up),
      .valid_o      (v[i]),
      .data_o       (d[i])
    );
  end

  assign in_ready  = g_stage[0].rdy_up && !flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  // Internal moves never change the beat count, so the popcount of the next
  // valid vector is the current count adjusted by the two end transfers.
  logic             in_xfer, out_xfer;
  logic [CNT_W-1:0] occ_q, occ_d;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (in_xfer && !out_xfer) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (!in_xfer && out_xfer) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign occupancy = occ_q;

endmodule
